// File: rtl/elm_hidden_collector_if.sv
// rtl/elm_hidden_collector_if.sv - activation stream from the hidden collector to the output layer
// master drives valid/data/idx/last, slave returns ready.
interface elm_hidden_collector_if #(
    parameter int OUT_W = 8,
    parameter int IDX_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/elm_hidden_collector.sv
// rtl/elm_hidden_collector.sv - captures hidden-neuron sums, activates, buffers and streams them out
// ELM_SIGNED_ACT_EN selects signed saturation instead of clipped-ReLU.
module elm_hidden_collector #(
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 8,
    parameter int NUM_HIDDEN = 64,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    per_load,
    input  logic [ACC_W-1:0]        acc_in,
    output logic                    stop,
    output logic                    busy,
    output logic                    ovf_err,
    elm_hidden_collector_if.master  out_if
);

    localparam int AW = $clog2(NUM_HIDDEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HIDDEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [OUT_W-1:0] mem [NUM_HIDDEN];

    logic             take;
    logic             last_cap;
    logic             xfer;
    logic             last_xfer;
    logic             draining;

    logic signed [ACC_W-1:0] s_val;
    logic [OUT_W-1:0]        act;

    assign s_val = $signed(acc_in) >>> FRAC_SHIFT;

`ifdef ELM_SIGNED_ACT_EN
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    always_comb begin
        act = '0;
        if (s_val < S_MIN) begin
            act = {1'b1, {(OUT_W-1){1'b0}}};
        end else if (s_val > S_MAX) begin
            act = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            act = s_val[OUT_W-1:0];
        end
    end
`else
    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((64'sd1 <<< OUT_W) - 64'sd1);

    always_comb begin
        act = '0;
        if (s_val[ACC_W-1]) begin
            act = '0;
        end else if (s_val > U_MAX) begin
            act = '1;
        end else begin
            act = s_val[OUT_W-1:0];
        end
    end
`endif

    // A start during COLLECT restarts the run and swallows any coincident sum.
    assign take      = (state == S_COLLECT) && per_load && !start;
    assign last_cap  = take && (wr_ptr == LAST_IDX);
    assign draining  = (state == S_DRAIN);
    assign xfer      = draining && out_if.out_ready;
    assign last_xfer = xfer && (rd_ptr == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_cap) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_xfer) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (start && (state != S_DRAIN)) begin
                wr_ptr <= '0;
            end else if (take) begin
                wr_ptr <= last_cap ? '0 : wr_ptr + IDX_W'(1);
            end

            if (last_cap) begin
                rd_ptr <= '0;
            end else if (xfer) begin
                rd_ptr <= last_xfer ? '0 : rd_ptr + IDX_W'(1);
            end
        end
    end

    // stop holds the controller in DONE from the final capture until the last word leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop <= 1'b0;
        end else if (last_cap) begin
            stop <= 1'b1;
        end else if (last_xfer) begin
            stop <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (per_load && (state != S_COLLECT)) begin
            ovf_err <= 1'b1;
        end else if (start && (state == S_IDLE)) begin
            ovf_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem[wr_ptr[AW-1:0]] <= act;
        end
    end

    // Buffer is never cleared, so the read port is gated to keep idle outputs at zero.
    assign out_if.out_valid = draining;
    assign out_if.out_data  = draining ? mem[rd_ptr[AW-1:0]] : '0;
    assign out_if.out_idx   = draining ? rd_ptr : '0;
    assign out_if.out_last  = draining && (rd_ptr == LAST_IDX);
    assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_elm_hidden_collector.sv
// tb/tb_elm_hidden_collector.sv - self-checking bench for elm_hidden_collector with NUM_HIDDEN=4
module tb_elm_hidden_collector;

    localparam int NH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        per_load = 1'b0;
    logic [23:0] acc_in = '0;
    logic        stop;
    logic        busy;
    logic        ovf_err;

    elm_hidden_collector_if #(.OUT_W(8), .IDX_W(8)) ifc ();

    elm_hidden_collector #(
        .ACC_W(24), .OUT_W(8), .FRAC_SHIFT(8), .NUM_HIDDEN(NH), .IDX_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .per_load (per_load),
        .acc_in   (acc_in),
        .stop     (stop),
        .busy     (busy),
        .ovf_err  (ovf_err),
        .out_if   (ifc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [23:0] vals [NH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] act_ref(input logic [23:0] a);
        int v;
        int s;
        v = int'($signed(a));
        s = v >>> 8;
`ifdef ELM_SIGNED_ACT_EN
        if (s < -128) s = -128;
        if (s > 127) s = 127;
`else
        if (s < 0) s = 0;
        if (s > 255) s = 255;
`endif
        return s[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic collect(input bit use_model, input bit gaps);
        for (int i = 0; i < NH; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            per_load = 1'b1;
            acc_in = vals[i];
            if (use_model) exp_q.push_back(act_ref(vals[i]));
            step();
            per_load = 1'b0;
            chk("stop_during_collect", {31'd0, stop}, {31'd0, (i == NH - 1)});
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        int k;
        int cyc;
        logic [3:0] pat;
        k = 0;
        cyc = 0;
        pat = 4'b1001;
        while (k < NH && cyc < 200) begin
            if (mode == 0) ifc.out_ready = 1'b1;
            else if (mode == 1) ifc.out_ready = pat[cyc % 4];
            else ifc.out_ready = 1'($urandom_range(0, 1));
            chk("out_valid", {31'd0, ifc.out_valid}, 32'd1);
            chk("stop_drain", {31'd0, stop}, 32'd1);
            chk("out_data", {24'd0, ifc.out_data}, {24'd0, exp_q[k]});
            chk("out_idx", {24'd0, ifc.out_idx}, k);
            chk("out_last", {31'd0, ifc.out_last}, {31'd0, (k == NH - 1)});
            step();
            if (ifc.out_ready) k++;
            cyc++;
        end
        ifc.out_ready = 1'b0;
        chk("drain_count", k, NH);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_stop", {31'd0, stop}, 32'd0);
        chk("idle_valid", {31'd0, ifc.out_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic set_test1_vals();
        vals[0] = 24'h000500;
        vals[1] = 24'hFFFF00;
        vals[2] = 24'h020000;
        vals[3] = 24'h000080;
    endtask

    initial begin
        ifc.out_ready = 1'b0;

        // reset state
        repeat (2) step();
        chk("rst_stop", {31'd0, stop}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
        chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_last", {31'd0, ifc.out_last}, 32'd0);
        chk("rst_data", {24'd0, ifc.out_data}, 32'd0);
        chk("rst_idx", {24'd0, ifc.out_idx}, 32'd0);
        #2 rst = 1'b1;
        step();

        // basic run, expectations from the worked example
        pulse_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        set_test1_vals();
        collect(1'b0, 1'b0);
        exp_q = '{8'd5, 8'd0, 8'd255, 8'd0};
        drain(0);

        // backpressure 1,0,0,1
        pulse_start();
        for (int i = 0; i < NH; i++) vals[i] = 24'($urandom_range(0, 131071)) - 24'd65536;
        collect(1'b1, 1'b1);
        drain(1);

        // overflow error in IDLE and DRAIN
        per_load = 1'b1;
        acc_in = 24'h00FF00;
        step();
        per_load = 1'b0;
        chk("t3_ovf_idle", {31'd0, ovf_err}, 32'd1);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);
        pulse_start();
        chk("t3_ovf_clr", {31'd0, ovf_err}, 32'd0);
        for (int i = 0; i < NH; i++) vals[i] = 24'($urandom);
        collect(1'b1, 1'b0);
        per_load = 1'b1;
        acc_in = 24'h7FFFFF;
        step();
        per_load = 1'b0;
        chk("t3_ovf_drain", {31'd0, ovf_err}, 32'd1);
        drain(2);
        chk("t3_ovf_sticky", {31'd0, ovf_err}, 32'd1);
        pulse_start();
        chk("t3_ovf_start_clr", {31'd0, ovf_err}, 32'd0);

        // async reset mid-collect
        per_load = 1'b1;
        acc_in = 24'h000300;
        step();
        step();
        per_load = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t4_busy_async", {31'd0, busy}, 32'd0);
        chk("t4_valid_async", {31'd0, ifc.out_valid}, 32'd0);
        chk("t4_stop_async", {31'd0, stop}, 32'd0);
        #2 rst = 1'b1;
        step();
        chk("t4_idle_after", {31'd0, busy}, 32'd0);
        pulse_start();
        set_test1_vals();
        collect(1'b0, 1'b0);
        exp_q = '{8'd5, 8'd0, 8'd255, 8'd0};
        drain(0);

        // start coincident with third per_load
        pulse_start();
        per_load = 1'b1;
        acc_in = 24'h001000;
        step();
        step();
        start = 1'b1;
        acc_in = 24'h00AA00;
        step();
        start = 1'b0;
        per_load = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd1);
        chk("t5_stop", {31'd0, stop}, 32'd0);
        for (int i = 0; i < NH; i++) vals[i] = 24'($urandom_range(0, 131071)) - 24'd65536;
        collect(1'b1, 1'b1);
        drain(2);

        // activation corner values for the configured build
        pulse_start();
        vals[0] = 24'hFFFF00;
        vals[1] = 24'hFF0000;
        vals[2] = 24'h010000;
        vals[3] = 24'h000100;
        collect(1'b0, 1'b0);
`ifdef ELM_SIGNED_ACT_EN
        exp_q = '{8'hFF, 8'h80, 8'h7F, 8'h01};
`else
        exp_q = '{8'h00, 8'h00, 8'hFF, 8'h01};
`endif
        drain(0);

        // random runs against the reference model
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            for (int i = 0; i < NH; i++) begin
                if ($urandom_range(0, 1) == 1) vals[i] = 24'($urandom);
                else vals[i] = 24'($urandom_range(0, 131071)) - 24'd65536;
            end
            collect(1'b1, 1'b1);
            drain(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
